// File: rtl/seg7_pkg.sv
// Shared types and constants for the scanned 7-segment display decoder.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int DIG_N = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    // Active-low segment patterns (bit6=a .. bit0=g, 0 = lit) for hex digits 0..F.
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
        7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
        7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
        7'h31, 7'h42, 7'h30, 7'h38    // C d E F
    };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-low segment pattern into a hex nibble.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] iPattern,
    output logic [3:0]       oNibble,
    output logic             oLegal
);

    // Search the hex table; a pattern that matches no entry is illegal.
    always_comb begin
        oNibble = 4'h0;
        oLegal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (iPattern == HEX_SEG[i]) begin
                oNibble = 4'(i);
                oLegal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 4-digit 7-segment display, waits for each digit's
// pattern to settle, decodes it and assembles complete 16-bit frames.
//
// Handshake: oFrameValid and oErr are single-cycle strobes with no ready;
// oValue is valid from the cycle oFrameValid is high until the next strobe.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [SEG_W-1:0] iSeg,
    input  logic [DIG_N-1:0] iAn,
    output logic [15:0]      oValue,
    output logic             oFrameValid,
    output logic             oErr,
    output logic [DIG_N-1:0] oDigitMask,
    output logic [1:0]       oDbgState
);

    localparam int SAMP_W = SEG_W + DIG_N;

    logic [SEG_W-1:0]  seg_s1_q, seg_s2_q;
    logic [DIG_N-1:0]  an_s1_q, an_s2_q;
    logic [SAMP_W-1:0] samp;
    logic [SAMP_W-1:0] prev_q, prev_d;
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       value_q, value_d;
    logic              fv_q, fv_d;
    logic              err_q, err_d;
    logic [DIG_N-1:0]  mask_q, mask_d;
    logic [DIG_N-1:0]  mask_new;
    logic              capture;
    logic              an_ok;
    logic [1:0]        digit_idx;
    logic [3:0]        nibble;
    logic              legal;

    assign samp = {an_s2_q, seg_s2_q};

    seg7_pattern_decode u_decode (
        .iPattern (seg_s2_q),
        .oNibble  (nibble),
        .oLegal   (legal)
    );

    // Exactly one active-low enable selects the digit being shown.
    always_comb begin
        an_ok     = 1'b1;
        digit_idx = 2'd0;
        case (an_s2_q)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    // Next-state: restart settling on any change, capture once when stable.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prev_d   = samp;
        shadow_d = shadow_q;
        value_d  = value_q;
        mask_d   = mask_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        capture  = 1'b0;
        mask_new = mask_q;

        if (samp != prev_q) begin
            cnt_d   = 8'd0;
            state_d = (an_ok && (seg_s2_q != {SEG_W{1'b1}})) ? S_COUNT : S_IDLE;
        end else if (state_q == S_COUNT) begin
            if (cnt_q == 8'(STABLE_CYCLES - 2)) begin
                capture = 1'b1;
                state_d = S_HELD;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (capture) begin
            if (legal) begin
                shadow_d[{digit_idx, 2'b00} +: 4] = nibble;
                mask_new = mask_q | (4'b0001 << digit_idx);
                if (mask_new == 4'b1111) begin
                    value_d = shadow_d;
                    fv_d    = 1'b1;
                    mask_d  = 4'b0000;
                end else begin
                    mask_d  = mask_new;
                end
            end else begin
                err_d  = 1'b1;
                mask_d = 4'b0000;
            end
        end
    end

    // Two-flop synchronizers; idle value is all-ones (nothing lit, no digit).
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            seg_s1_q <= {SEG_W{1'b1}};
            seg_s2_q <= {SEG_W{1'b1}};
            an_s1_q  <= {DIG_N{1'b1}};
            an_s2_q  <= {DIG_N{1'b1}};
        end else begin
            seg_s1_q <= iSeg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= iAn;
            an_s2_q  <= an_s1_q;
        end
    end

    // State, counter, shadow slots and registered outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prev_q   <= {SAMP_W{1'b1}};
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            shadow_q <= 16'h0000;
            value_q  <= 16'h0000;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            mask_q   <= 4'b0000;
        end else begin
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            value_q  <= value_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
        end
    end

    assign oValue      = value_q;
    assign oFrameValid = fv_q;
    assign oErr        = err_q;
    assign oDigitMask  = mask_q;
    assign oDbgState   = state_q;

endmodule
